satd_block_loader: RTL and testbench

- Producer side of the SATD block interface.
- Accepts original (ORG) and current (CUR) pixel rows one row per beat over a valid/ready stream.
- Assembles them into the two flat 1024-bit block buses consumed by the SATD datapath.
- Holds the complete block stable with a valid/ack handshake until the SATD side accepts it, then reloads.

---
 rtl/satd_pkg.sv | 26 ++
 rtl/satd_row_buffer.sv | 37 +++
 rtl/satd_block_loader.sv | 154 +++++++++++++++
 tb/tb_satd_block_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/satd_pkg.sv
// Shared definitions for the SATD block loader: geometry defaults, loader
// state encoding and the row-index to bit-offset helper used when flattening
// row buffers onto the block buses.
package satd_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned SAMPLES_DEF = 8;
  localparam int unsigned ROWS_DEF    = 16;
  localparam int unsigned ROW_W_DEF   = WIDTH_DEF * SAMPLES_DEF;
  localparam int unsigned BLK_W_DEF   = ROWS_DEF * ROW_W_DEF;

  typedef enum logic [1:0] {
    LOAD_ORG = 2'd0,
    LOAD_CUR = 2'd1,
    HOLD     = 2'd2
  } satd_state_e;

  // Row 0 occupies the most significant row slot, so the bus reads like a
  // concatenation {row0, row1, ..., rowN-1}.
  function automatic int unsigned row_lsb(input int unsigned row,
                                          input int unsigned rows,
                                          input int unsigned row_w);
    return (rows - 1 - row) * row_w;
  endfunction

endpackage

// File: rtl/satd_row_buffer.sv
// ROWS x ROW_W register file written one row at a time, presented as one flat
// bus with row 0 in the MSBs.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears all rows)
//   we_i      - write enable for the row selected by idx_i
//   idx_i     - row index to write
//   row_i     - row data
//   blk_o     - flattened contents, row 0 at [BLK_W-1 -: ROW_W]
module satd_row_buffer
  import satd_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(ROWS)-1:0]  idx_i,
  input  logic [ROW_W-1:0]         row_i,
  output logic [ROWS*ROW_W-1:0]    blk_o
);

  logic [ROW_W-1:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[idx_i] <= row_i;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign blk_o[row_lsb(r, ROWS, ROW_W) +: ROW_W] = mem_q[r];
  end

endmodule

// File: rtl/satd_block_loader.sv
// Producer side of the SATD block interface. Collects ROWS original rows and
// then ROWS current rows from a valid/ready row stream, and presents them as
// the ORG/CUR block buses held stable under blk_valid until blk_ack.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   in_valid/ready  - row beat handshake (in_ready never depends on in_valid)
//   in_row          - one row per beat, first sample in the MSBs
//   in_last         - expected on the final CUR beat only
//   ORG, CUR        - assembled block buses
//   blk_valid/ack   - block hand-off to the SATD datapath
//   frame_err       - sticky framing error, cleared by rst only
//   blocks_done     - wrapping count of acknowledged blocks
//
// state    | meaning
// LOAD_ORG | accepting rows into ORG, counter = next row index
// LOAD_CUR | accepting rows into CUR, counter = next row index
// HOLD     | complete block presented, waiting for blk_ack
module satd_block_loader
  import satd_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SAMPLES = SAMPLES_DEF,
  parameter int unsigned ROWS    = ROWS_DEF,
  localparam int unsigned ROW_W  = WIDTH * SAMPLES,
  localparam int unsigned BLK_W  = ROWS * ROW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  input  logic             in_last,
  output logic [BLK_W-1:0] ORG,
  output logic [BLK_W-1:0] CUR,
  output logic             blk_valid,
  input  logic             blk_ack,
  output logic             frame_err,
  output logic [15:0]      blocks_done
);

  localparam int unsigned      CNT_W    = $clog2(ROWS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  satd_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      done_q, done_d;

  logic xfer;
  logic last_row;

  assign in_ready = ~rst & (state_q != HOLD);
  assign xfer     = in_valid & in_ready;
  assign last_row = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_ORG;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    done_d  = done_q;
    unique case (state_q)
      LOAD_ORG: begin
        if (xfer) begin
          if (in_last) begin
            // Premature end of block: keep the written row, restart framing.
            err_d = 1'b1;
            cnt_d = '0;
          end else if (last_row) begin
            state_d = LOAD_CUR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_CUR: begin
        if (xfer) begin
          if (last_row) begin
            // Block completes regardless of in_last; a missing marker is
            // still flagged.
            state_d = HOLD;
            cnt_d   = '0;
            valid_d = 1'b1;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = LOAD_ORG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (blk_ack) begin
          valid_d = 1'b0;
          done_d  = done_q + 16'd1;
          state_d = LOAD_ORG;
        end
      end
      default: begin
        state_d = LOAD_ORG;
        cnt_d   = '0;
      end
    endcase
  end

  satd_row_buffer #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_org_buf (
    .clk   (clk),
    .rst   (rst),
    .we_i  (xfer && (state_q == LOAD_ORG)),
    .idx_i (cnt_q),
    .row_i (in_row),
    .blk_o (ORG)
  );

  satd_row_buffer #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_cur_buf (
    .clk   (clk),
    .rst   (rst),
    .we_i  (xfer && (state_q == LOAD_CUR)),
    .idx_i (cnt_q),
    .row_i (in_row),
    .blk_o (CUR)
  );

  assign blk_valid   = valid_q;
  assign frame_err   = err_q;
  assign blocks_done = done_q;

endmodule

// File: tb/tb_satd_block_loader.sv
// Self-checking bench for satd_block_loader. Rows are random; the expected
// buses are built from row arrays by concatenation, and the expected flags
// and counters follow the block protocol rules.
module tb_satd_block_loader;

  typedef logic [63:0] rows_t [16];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_row = '0;
  logic          in_last = 1'b0;
  logic [1023:0] ORG;
  logic [1023:0] CUR;
  logic          blk_valid;
  logic          blk_ack = 1'b0;
  logic          frame_err;
  logic [15:0]   blocks_done;

  rows_t exp_org;
  rows_t exp_cur;
  logic  exp_err;
  int    exp_done;
  logic  pre_valid;
  logic  pre_err;
  int    checks = 0;
  int    errors = 0;

  satd_block_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_last     (in_last),
    .ORG         (ORG),
    .CUR         (CUR),
    .blk_valid   (blk_valid),
    .blk_ack     (blk_ack),
    .frame_err   (frame_err),
    .blocks_done (blocks_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [1023:0] pack(input rows_t r);
    logic [1023:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[959:0], r[i]};
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    blk_ack = 1'b0;
    step();
    rst = 1'b0;
    exp_err = 1'b0;
    exp_done = 0;
  endtask

  // Streams 32 beats; gaps and ignored acks are inserted at random.
  task automatic load_block(input bit fixed, input bit missing_last,
                            input int gap_pct, input bit ack_noise);
    logic [63:0] row;
    int g;
    for (int i = 0; i < 32; i++) begin
      row = {$urandom, $urandom};
      if (fixed && i == 0) row = 64'h36ADEB33333BDB49;
      if (fixed && i == 1) row = 64'h5555555555555555;
      if (i < 16) exp_org[i] = row;
      else        exp_cur[i-16] = row;
      g = 0;
      while (g < 4 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_row = {$urandom, $urandom};
        in_last = $urandom_range(1);
        blk_ack = ack_noise ? 1'($urandom_range(1)) : 1'b0;
        step();
        g++;
      end
      in_valid = 1'b1;
      in_row = row;
      in_last = (i == 31) ? !missing_last : 1'b0;
      blk_ack = (ack_noise && i != 31) ? 1'($urandom_range(1)) : 1'b0;
      if (i == 31) begin
        pre_valid = blk_valid;
        pre_err = frame_err;
      end
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    blk_ack = 1'b0;
    if (missing_last) exp_err = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_row = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
    end
    checks++;
    if (ORG !== '0) begin errors++; $display("FAIL reset_org: got %h want 0", ORG); end
    checks++;
    if (CUR !== '0) begin errors++; $display("FAIL reset_cur: got %h want 0", CUR); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", blk_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    checks++;
    if (blocks_done !== 16'd0) begin errors++; $display("FAIL reset_done: got %0d want 0", blocks_done); end
    rst = 1'b0;
    in_valid = 1'b0;
    exp_err = 1'b0;
    exp_done = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_block();
    load_block(1'b1, 1'b0, 0, 1'b0);
    checks++;
    if (pre_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b want 0", pre_valid); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", blk_valid); end
    checks++;
    if (ORG[1023:960] !== 64'h36ADEB33333BDB49) begin
      errors++; $display("FAIL full_org_row0: got %h want 36adeb33333bdb49", ORG[1023:960]);
    end
    checks++;
    if (CUR[63:0] !== exp_cur[15]) begin
      errors++; $display("FAIL full_cur_row15: got %h want %h", CUR[63:0], exp_cur[15]);
    end
    checks++;
    if (ORG !== pack(exp_org)) begin errors++; $display("FAIL full_org: got %h want %h", ORG, pack(exp_org)); end
    checks++;
    if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL full_cur: got %h want %h", CUR, pack(exp_cur)); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", frame_err); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b want 0", in_ready); end
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    exp_done++;
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL full_ack_valid: got %b want 0", blk_valid); end
    checks++;
    if (blocks_done !== 16'(exp_done)) begin
      errors++; $display("FAIL full_done: got %0d want %0d", blocks_done, exp_done);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ack_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    load_block(1'b0, 1'b0, 35, 1'b1);
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", blk_valid); end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_row = {$urandom, $urandom};
      in_last = $urandom_range(1);
      step();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
      checks++;
      if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", blk_valid); end
      checks++;
      if (ORG !== pack(exp_org)) begin errors++; $display("FAIL bp_hold_org: got %h want %h", ORG, pack(exp_org)); end
      checks++;
      if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL bp_hold_cur: got %h want %h", CUR, pack(exp_cur)); end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    exp_done++;
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL bp_ack_valid: got %b want 0", blk_valid); end
    checks++;
    if (blocks_done !== 16'(exp_done)) begin
      errors++; $display("FAIL bp_done: got %0d want %0d", blocks_done, exp_done);
    end
    // A fresh load must begin at ORG row 0.
    load_block(1'b0, 1'b0, 20, 1'b0);
    checks++;
    if (ORG !== pack(exp_org)) begin errors++; $display("FAIL bp_next_org: got %h want %h", ORG, pack(exp_org)); end
    checks++;
    if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL bp_next_cur: got %h want %h", CUR, pack(exp_cur)); end
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    exp_done++;
  endtask

  task automatic test_early_last();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_row = {$urandom, $urandom};
      in_last = (i == 9);
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    exp_err = 1'b1;
    step();
    checks++;
    if (frame_err !== exp_err) begin errors++; $display("FAIL early_err: got %b want %b", frame_err, exp_err); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", blk_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL early_ready: got %b want 1", in_ready); end
    load_block(1'b0, 1'b0, 10, 1'b0);
    checks++;
    if (pre_valid !== 1'b0) begin errors++; $display("FAIL early_pre_valid: got %b want 0", pre_valid); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $display("FAIL early_next_valid: got %b want 1", blk_valid); end
    checks++;
    if (ORG !== pack(exp_org)) begin errors++; $display("FAIL early_org: got %h want %h", ORG, pack(exp_org)); end
    checks++;
    if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL early_cur: got %h want %h", CUR, pack(exp_cur)); end
    checks++;
    if (frame_err !== exp_err) begin errors++; $display("FAIL early_sticky: got %b want %b", frame_err, exp_err); end
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    exp_done++;
    checks++;
    if (blocks_done !== 16'(exp_done)) begin
      errors++; $display("FAIL early_done: got %0d want %0d", blocks_done, exp_done);
    end
  endtask

  task automatic test_missing_last();
    apply_reset();
    load_block(1'b0, 1'b1, 15, 1'b0);
    checks++;
    if (pre_err !== 1'b0) begin errors++; $display("FAIL miss_pre_err: got %b want 0", pre_err); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $display("FAIL miss_valid: got %b want 1", blk_valid); end
    checks++;
    if (frame_err !== exp_err) begin errors++; $display("FAIL miss_err: got %b want %b", frame_err, exp_err); end
    checks++;
    if (ORG !== pack(exp_org)) begin errors++; $display("FAIL miss_org: got %h want %h", ORG, pack(exp_org)); end
    checks++;
    if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL miss_cur: got %h want %h", CUR, pack(exp_cur)); end
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    exp_done++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_row = {$urandom, $urandom};
      in_last = 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    in_valid = 1'b0;
    exp_err = 1'b0;
    exp_done = 0;
    checks++;
    if (ORG !== '0) begin errors++; $display("FAIL mid_org: got %h want 0", ORG); end
    checks++;
    if (CUR !== '0) begin errors++; $display("FAIL mid_cur: got %h want 0", CUR); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", frame_err); end
    checks++;
    if (blocks_done !== 16'd0) begin errors++; $display("FAIL mid_done: got %0d want 0", blocks_done); end
    load_block(1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid: got %b want 1", blk_valid); end
    checks++;
    if (ORG !== pack(exp_org)) begin errors++; $display("FAIL mid_next_org: got %h want %h", ORG, pack(exp_org)); end
    checks++;
    if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL mid_next_cur: got %h want %h", CUR, pack(exp_cur)); end
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    exp_done++;
    checks++;
    if (blocks_done !== 16'(exp_done)) begin
      errors++; $display("FAIL mid_next_done: got %0d want %0d", blocks_done, exp_done);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      load_block(1'b0, 1'b0, 0, 1'b0);
      checks++;
      if (blk_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", blk_valid); end
      checks++;
      if (ORG !== pack(exp_org)) begin errors++; $display("FAIL b2b_org: got %h want %h", ORG, pack(exp_org)); end
      checks++;
      if (CUR !== pack(exp_cur)) begin errors++; $display("FAIL b2b_cur: got %h want %h", CUR, pack(exp_cur)); end
      blk_ack = 1'b1;
      step();
      blk_ack = 1'b0;
      exp_done++;
      checks++;
      if (blocks_done !== 16'(exp_done)) begin
        errors++; $display("FAIL b2b_done: got %0d want %0d", blocks_done, exp_done);
      end
    end
    checks++;
    if (frame_err !== exp_err) begin errors++; $display("FAIL b2b_err: got %b want %b", frame_err, exp_err); end
  endtask

  initial begin
    exp_err = 1'b0;
    exp_done = 0;
    pre_valid = 1'b0;
    pre_err = 1'b0;
    test_reset();
    test_full_block();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
